tree_deserializer: RTL and testbench

- Receive-side counterpart of the tree serializer: collects one serial bit per enabled CLK cycle and reassembles INPUTS_NUM-bit parallel words.
- Undoes the serializer's tree (bit-reversed) bit ordering, or uses plain LSB-first ordering.
- Provides word-boundary alignment: manual bitslip plus an automatic training-pattern hunt FSM. Sits at the link input, ahead of word-level consumers.

---
 rtl/tree_deserializer.sv | 130 +++++++++++++
 tb/tb_tree_deserializer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/tree_deserializer.sv
// Serial-to-parallel receiver with tree (bit-reversed) or LSB-first bit ordering,
// manual bitslip and an automatic training-pattern alignment hunt.
`timescale 1ns/1ps
module tree_deserializer #(
  parameter int                    INPUTS_NUM    = 8,
  parameter int                    STAGES_NUM    = $clog2(INPUTS_NUM),
  parameter bit                    TREE_ORDER    = 1'b1,
  parameter logic [INPUTS_NUM-1:0] TRAIN_PATTERN = 8'hB8,
  parameter int                    MATCH_COUNT   = 4
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  SERIAL_IN,
  input  logic                  EN,
  input  logic                  BITSLIP,
  input  logic                  ALIGN_REQ,
  output logic [INPUTS_NUM-1:0] PAR_OUT,
  output logic                  PAR_VALID,
  output logic                  ALIGNED,
  output logic                  ALIGN_FAIL
);

  localparam int MCW = $clog2(MATCH_COUNT + 1);

  typedef enum logic [1:0] {
    UNLOCKED,
    HUNT,
    LOCKED
  } state_t;

  state_t                  state_reg;
  logic [STAGES_NUM-1:0]   bit_cnt_reg;
  logic [STAGES_NUM-1:0]   slip_cnt_reg;
  logic [MCW-1:0]          match_cnt_reg;
  logic [INPUTS_NUM-1:0]   asm_reg;
  logic                    auto_slip_reg;

  logic [STAGES_NUM-1:0]   wr_idx;
  logic [INPUTS_NUM-1:0]   word_next;
  logic                    manual_slip;
  logic                    slip_now;
  logic                    capture;
  logic                    word_done;

  // Destination bit of the current serial position: bit-reversed counter in tree order.
  for (genvar gi = 0; gi < STAGES_NUM; gi++) begin : g_map
    assign wr_idx[gi] = TREE_ORDER ? bit_cnt_reg[STAGES_NUM-1-gi] : bit_cnt_reg[gi];
  end

  // Assembly register with the incoming bit merged in, so a completing word is whole.
  for (genvar gi = 0; gi < INPUTS_NUM; gi++) begin : g_word
    assign word_next[gi] = (wr_idx == STAGES_NUM'(gi)) ? SERIAL_IN : asm_reg[gi];
  end

  // ALIGN_REQ pre-empts both manual and armed automatic slips.
  assign manual_slip = BITSLIP && (state_reg != HUNT);
  assign slip_now    = EN && !ALIGN_REQ && (auto_slip_reg || manual_slip);
  assign capture     = EN && !slip_now;
  assign word_done   = capture && (bit_cnt_reg == STAGES_NUM'(INPUTS_NUM - 1));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg     <= UNLOCKED;
      bit_cnt_reg   <= '0;
      slip_cnt_reg  <= '0;
      match_cnt_reg <= '0;
      asm_reg       <= '0;
      auto_slip_reg <= 1'b0;
      PAR_OUT       <= '0;
      PAR_VALID     <= 1'b0;
      ALIGNED       <= 1'b0;
      ALIGN_FAIL    <= 1'b0;
    end else begin
      PAR_VALID <= 1'b0;
      if (capture) begin
        asm_reg     <= word_next;
        bit_cnt_reg <= bit_cnt_reg + 1'b1;
      end
      if (slip_now) begin
        auto_slip_reg <= 1'b0;
      end
      if (word_done) begin
        PAR_OUT   <= word_next;
        PAR_VALID <= 1'b1;
      end

      if (ALIGN_REQ) begin
        state_reg     <= HUNT;
        match_cnt_reg <= '0;
        slip_cnt_reg  <= '0;
        auto_slip_reg <= 1'b0;
        ALIGN_FAIL    <= 1'b0;
        ALIGNED       <= 1'b0;
      end else begin
        case (state_reg)
          HUNT: begin
            if (word_done) begin
              if (word_next == TRAIN_PATTERN) begin
                match_cnt_reg <= match_cnt_reg + 1'b1;
                if (match_cnt_reg == MCW'(MATCH_COUNT - 1)) begin
                  state_reg <= LOCKED;
                  ALIGNED   <= 1'b1;
                end
              end else begin
                match_cnt_reg <= '0;
                // Every offset has been tried once the slip counter is saturated.
                if (slip_cnt_reg == STAGES_NUM'(INPUTS_NUM - 1)) begin
                  state_reg  <= UNLOCKED;
                  ALIGN_FAIL <= 1'b1;
                end else begin
                  slip_cnt_reg  <= slip_cnt_reg + 1'b1;
                  auto_slip_reg <= 1'b1;
                end
              end
            end
          end
          LOCKED: begin
            if (EN && BITSLIP) begin
              state_reg <= UNLOCKED;
              ALIGNED   <= 1'b0;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tree_deserializer.sv
// Self-checking bench for tree_deserializer: scoreboard of expected words and
// completion cycles, plus direct checks of alignment status outputs.
`timescale 1ns/1ps
module tb_tree_deserializer;

  logic       clk = 1'b0;
  logic       rst, ser, en, bitslip, align_req;
  logic [7:0] par_out;
  logic       par_valid, aligned, align_fail;

  logic       rst0, ser0, en0, bitslip0, align_req0;
  logic [7:0] par_out0;
  logic       par_valid0, aligned0, align_fail0;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  typedef struct {
    logic [7:0] word;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  logic sbits[$];
  int   ends[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tree_deserializer dut (
    .CLK(clk), .RESET(rst), .SERIAL_IN(ser), .EN(en), .BITSLIP(bitslip),
    .ALIGN_REQ(align_req), .PAR_OUT(par_out), .PAR_VALID(par_valid),
    .ALIGNED(aligned), .ALIGN_FAIL(align_fail)
  );

  tree_deserializer #(.TREE_ORDER(1'b0)) dut0 (
    .CLK(clk), .RESET(rst0), .SERIAL_IN(ser0), .EN(en0), .BITSLIP(bitslip0),
    .ALIGN_REQ(align_req0), .PAR_OUT(par_out0), .PAR_VALID(par_valid0),
    .ALIGNED(aligned0), .ALIGN_FAIL(align_fail0)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // Tree order: serial position k lands in word bit bitrev3(k).
  function automatic logic [7:0] pack_at(input int s);
    logic [7:0] w;
    logic [2:0] k3;
    w = '0;
    for (int k = 0; k < 8; k++) begin
      k3 = k[2:0];
      w[{k3[0], k3[1], k3[2]}] = sbits[s + k];
    end
    return w;
  endfunction

  function automatic void push_word(input logic [7:0] w);
    for (int k = 0; k < 8; k++) begin
      logic [2:0] k3;
      k3 = k[2:0];
      sbits.push_back(w[{k3[0], k3[1], k3[2]}]);
    end
  endfunction

  always @(negedge clk) begin
    if (par_valid) begin
      if (sb.size() == 0) begin
        check("spurious_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("par_out", {24'd0, par_out}, {24'd0, e.word});
        check("valid_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic run_range(input int lo, input int hi, input int slip_idx);
    for (int i = lo; i < hi; i++) begin
      @(posedge clk); #1;
      en      = 1'b1;
      ser     = sbits[i];
      bitslip = (i == slip_idx);
      if (ends.size() > 0 && ends[0] == i) begin
        sb.push_back(exp_t'{pack_at(i - 7), cyc + 1});
        void'(ends.pop_front());
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      en = 1'b0; ser = 1'b0; bitslip = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; en = 1'b0; bitslip = 1'b0; align_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic pulse_align();
    @(posedge clk); #1;
    en = 1'b0; align_req = 1'b1;
    @(posedge clk); #1;
    align_req = 1'b0;
  endtask

  task automatic stream0(input logic [7:0] pat);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      en0 = 1'b1; ser0 = pat[k];
    end
    @(posedge clk); #1;
    en0 = 1'b0;
    check("lsb_valid", {31'd0, par_valid0}, 32'd1);
    check("lsb_word", {24'd0, par_out0}, {24'd0, pat});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] pat;
    rst = 1'b1; ser = 1'b0; en = 1'b0; bitslip = 1'b0; align_req = 1'b0;
    rst0 = 1'b1; ser0 = 1'b0; en0 = 1'b0; bitslip0 = 1'b0; align_req0 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; rst0 = 1'b0;

    check("rst_par_out", {24'd0, par_out}, 32'd0);
    check("rst_par_valid", {31'd0, par_valid}, 32'd0);
    check("rst_aligned", {31'd0, aligned}, 32'd0);
    check("rst_align_fail", {31'd0, align_fail}, 32'd0);

    // Tree-ordered 0xA5 (serial 1,0,1,0,0,1,0,1)
    sbits = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    ends = '{7};
    run_range(0, 8, -1);
    idle(1);
    check("tree_a5", {24'd0, par_out}, 32'hA5);
    idle(1);

    // Reset mid-word: five bits, reset, then a fresh word 0x01
    sbits = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
              1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    ends.delete();
    run_range(0, 5, -1);
    do_reset();
    check("midrst_par_out", {24'd0, par_out}, 32'd0);
    check("midrst_valid", {31'd0, par_valid}, 32'd0);
    ends = '{12};
    run_range(5, 13, -1);
    idle(2);
    check("fresh_word", {24'd0, par_out}, 32'h01);

    // EN gap of 3 cycles after bit 4
    do_reset();
    sbits = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    ends = '{7};
    run_range(0, 4, -1);
    idle(3);
    run_range(4, 8, -1);
    idle(2);
    check("gap_a5", {24'd0, par_out}, 32'hA5);

    // LSB-first instance
    pat = 8'hA5;
    stream0(pat);
    pat = 8'h01;
    stream0(pat);

    // Auto-align: 3 junk bits then continuous training words
    do_reset();
    pulse_align();
    check("hunt_aligned", {31'd0, aligned}, 32'd0);
    check("hunt_fail", {31'd0, align_fail}, 32'd0);
    sbits = '{1'b1, 1'b1, 1'b1};
    for (int w = 0; w < 10; w++) push_word(8'hB8);
    ends = '{7, 16, 25, 34, 42, 50, 58, 66};
    run_range(0, 51, -1);
    idle(1);
    check("three_matches_unaligned", {31'd0, aligned}, 32'd0);
    run_range(51, 59, -1);
    idle(1);
    check("locked_aligned", {31'd0, aligned}, 32'd1);
    check("locked_word", {24'd0, par_out}, 32'hB8);
    run_range(59, 67, -1);
    idle(1);
    check("still_aligned", {31'd0, aligned}, 32'd1);
    check("locked_word2", {24'd0, par_out}, 32'hB8);

    // Lock loss via manual bitslip
    ends = '{75};
    run_range(67, 68, 67);
    idle(1);
    check("slip_unaligned", {31'd0, aligned}, 32'd0);
    run_range(68, 76, -1);
    idle(2);

    // Hunt failure on an all-zero stream
    do_reset();
    pulse_align();
    sbits.delete();
    for (int i = 0; i < 71; i++) sbits.push_back(1'b0);
    ends = '{7, 16, 25, 34, 43, 52, 61, 70};
    run_range(0, 70, -1);
    idle(1);
    check("fail_not_yet", {31'd0, align_fail}, 32'd0);
    run_range(70, 71, -1);
    idle(1);
    check("fail_set", {31'd0, align_fail}, 32'd1);
    check("fail_unaligned", {31'd0, aligned}, 32'd0);
    idle(2);
    check("fail_sticky", {31'd0, align_fail}, 32'd1);
    pulse_align();
    check("fail_cleared", {31'd0, align_fail}, 32'd0);

    idle(3);
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
